sha256_round_ctrl: RTL and testbench
====================================

# sha256_round_ctrl

Round sequencer and job controller that drives the control side of the SHA-256 compression core. It accepts a 512-bit pre-padded message template and a nonce range from the host. For each nonce it inserts the value into the template and sequences the core through reset, load, W prefetch, 64 rounds and the final addition, supplying the round constant K each cycle. It samples the core's `found` flag and reports the first hit, or completion of the range, to the host.

## Interface
- `NONCE_LSB`, default 96: bit position of the 32-bit nonce field inside `message`. Legal values are 0..480.
- `clk_fast`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `job_valid`  in  1  host offers a job
- `job_ready`  out  1  controller can accept a job; combinational, equals (state==IDLE)
- `job_template`  in  512  padded block; nonce field is overwritten
- `nonce_start`  in  32  first nonce
- `nonce_count`  in  32  number of nonces to test; 0 is treated as 1
- `abort`  in  1  cancel the job in progress
- `busy`  out  1  job in progress
- `done`  out  1  one-cycle pulse at job end
- `hit`  out  1  valid with `done`: a match was found
- `hit_nonce`  out  32  nonce that matched; held until the next job is accepted
- `message`  out  512  to core
- `round`  out  7  to core
- `rotate_W`, `start`, `round_enable`, `enable_last_addition`, `idle_rst`  out  1 each  to core
- `K`  out  32  to core, registered
- `found`  in  1  from core

## Operation
- Reset value of all registered outputs is 0. `job_ready`=1 because the state is IDLE.
- A job is accepted when `job_valid && job_ready`. On acceptance, latch the template, `nonce_start` and `nonce_count`; set `busy`=1; clear `hit_nonce`.
- The FSM runs LOAD → PREP → ROUND (64 cycles) → FINAL → CHECK for each nonce.
- **IDLE**: all core controls are 0; `K`=0; `round`=0.
- **LOAD** (1 cycle): `start`=1, `idle_rst`=1, `rotate_W`=0. `message` = template with bits [NONCE_LSB+31:NONCE_LSB] replaced by the current nonce. `message` is stable from LOAD through CHECK.
- **PREP** (1 cycle): `rotate_W`=1, `round_enable`=0. This cycle lets the core pre-add W0+H. `K` is loaded with K[0] for the next cycle.
- **ROUND t** (t=0..63): `round_enable`=1, `round`=t, `K`=K[t] (FIPS 180-4 table). `rotate_W`=1 for t=0..62 and 0 at t=63.
- **FINAL** (1 cycle): `enable_last_addition`=1, `round`=64, `K`=0.
- **CHECK** (1 cycle): `round`=64; sample `found`.
  - If `found`=1: `hit`=1, `hit_nonce`=current nonce, `done` pulse, go to IDLE.
  - Else if remaining>1: decrement remaining, nonce+1 (wraps mod 2^32), go to LOAD.
  - Else: `done` pulse with `hit`=0, go to IDLE.
- `abort` has priority in every non-IDLE state. The next state is IDLE with all core controls 0, no `done`, and `hit_nonce` unchanged.
- `rst` mid-job: the next cycle is IDLE with reset values. No `done`.
- `job_valid` while busy is ignored because `job_ready`=0.

## Timing
- One nonce takes 68 cycles: LOAD 1, PREP 1, ROUND 64, FINAL 1, CHECK 1.
- Acceptance cycle is c. LOAD is at c+1. ROUND 0 is at c+3. CHECK is at c+68. `done` is high in cycle c+68.
- For nonce n (0-based), CHECK is at c+68(n+1). A new job can be accepted in the cycle after `done`.
- `rotate_W` leads `round_enable` by one cycle. `K` and `round` change in the same cycle as state.
- `done` is high for exactly one cycle. `busy` falls together with `done` or `abort`.

## Configuration
- `SHA_NONCE_SWEEP_EN`
  - Defined: full nonce sweep as described, including counter, increment and wrap.
  - Undefined: `nonce_count` is ignored. Exactly one hash runs with `nonce_start`, and CHECK always goes to IDLE with a `done` pulse. The remaining-count register and incrementer are not synthesised.

## Test plan
- Real core, template = "abc" padded (word0=0x61626380, words1..14=0, word15=0x18, NONCE_LSB=96, nonce_start=0), macro undefined → `done` at c+68, `hit`=0, core H = 0xf20015ad in CHECK.
- Monitor `K`: ROUND 0 = 0x428a2f98, ROUND 1 = 0x71374491, ROUND 63 = 0xc67178f2. `rotate_W` is high from PREP through ROUND 62.
- Stub core with `found`=1 when message[127:96]==5; nonce_start=2, nonce_count=10 → `hit`=1, `hit_nonce`=5, `done` at c+272.
- nonce_start=0xFFFFFFFF, nonce_count=2, no hit → LOAD nonces 0xFFFFFFFF then 0x00000000; `done` at c+136 with `hit`=0.
- `abort` at ROUND 30 → IDLE next cycle, no `done`, `job_ready`=1. `rst` at ROUND 10 of a second job gives the same result with all outputs 0.
- nonce_count=0 → exactly one hash, `done` at c+68.

Source files
------------

// File: rtl/sha256_round_ctrl_if.sv
// Host job handshake and core control bundle for sha256_round_ctrl.
// The slave modport is the controller's view; master is the host/core side.
interface sha256_round_ctrl_if;
    logic         job_valid;
    logic         job_ready;
    logic [511:0] job_template;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_count;
    logic         abort;
    logic         busy;
    logic         done;
    logic         hit;
    logic [31:0]  hit_nonce;
    logic [511:0] message;
    logic [6:0]   round;
    logic         rotate_W;
    logic         start;
    logic         round_enable;
    logic         enable_last_addition;
    logic         idle_rst;
    logic [31:0]  K;
    logic         found;

    modport slave (
        input  job_valid, job_template, nonce_start, nonce_count, abort, found,
        output job_ready, busy, done, hit, hit_nonce, message, round, rotate_W,
               start, round_enable, enable_last_addition, idle_rst, K
    );

    modport master (
        output job_valid, job_template, nonce_start, nonce_count, abort, found,
        input  job_ready, busy, done, hit, hit_nonce, message, round, rotate_W,
               start, round_enable, enable_last_addition, idle_rst, K
    );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer / nonce job controller: LOAD, PREP, 64 rounds, FINAL, CHECK per nonce.
// Define SHA_NONCE_SWEEP_EN to sweep nonce_count nonces; otherwise one hash per job.
module sha256_round_ctrl #(
    parameter int NONCE_LSB = 96
) (
    input logic clk_fast,
    input logic rst,
    sha256_round_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, PREP, ROUND, FINAL, CHECK} state_t;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t       state, state_nxt;
    logic [5:0]   rnd, rnd_nxt;
    logic [511:0] tmpl;
    logic [31:0]  nonce;
    logic [31:0]  hit_nonce_reg;
    logic [31:0]  k_reg;
    logic         accept;
    logic         last;

`ifdef SHA_NONCE_SWEEP_EN
    logic [31:0] remaining;
    assign last = (remaining <= 32'd1);
`else
    logic unused_count;
    assign unused_count = ^bus.nonce_count;
    assign last = 1'b1;
`endif

    assign accept        = (state == IDLE) && bus.job_valid;
    assign bus.K         = k_reg;
    assign bus.hit_nonce = hit_nonce_reg;

    always_comb begin
        bus.message = tmpl;
        bus.message[NONCE_LSB +: 32] = nonce;
    end

    always_comb begin
        state_nxt                = state;
        rnd_nxt                  = rnd;
        bus.job_ready            = (state == IDLE);
        bus.busy                 = (state != IDLE);
        bus.done                 = 1'b0;
        bus.hit                  = 1'b0;
        bus.round                = 7'd0;
        bus.rotate_W             = 1'b0;
        bus.start                = 1'b0;
        bus.round_enable         = 1'b0;
        bus.enable_last_addition = 1'b0;
        bus.idle_rst             = 1'b0;
        unique case (state)
            IDLE: if (bus.job_valid) state_nxt = LOAD;
            LOAD: begin
                bus.start    = 1'b1;
                bus.idle_rst = 1'b1;
                state_nxt    = PREP;
            end
            PREP: begin
                // W0+H pre-add cycle; the round counter is primed for ROUND 0
                bus.rotate_W = 1'b1;
                rnd_nxt      = 6'd0;
                state_nxt    = ROUND;
            end
            ROUND: begin
                bus.round_enable = 1'b1;
                bus.rotate_W     = (rnd != 6'd63);
                bus.round        = {1'b0, rnd};
                if (rnd == 6'd63) state_nxt = FINAL;
                else              rnd_nxt   = rnd + 6'd1;
            end
            FINAL: begin
                bus.enable_last_addition = 1'b1;
                bus.round                = 7'd64;
                state_nxt                = CHECK;
            end
            CHECK: begin
                bus.round = 7'd64;
                if (bus.found || last) begin
                    bus.done  = 1'b1;
                    bus.hit   = bus.found;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // abort overrides every active state and suppresses the done pulse
        if (state != IDLE && bus.abort) begin
            state_nxt = IDLE;
            bus.done  = 1'b0;
            bus.hit   = 1'b0;
        end
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state         <= IDLE;
            rnd           <= 6'd0;
            k_reg         <= 32'd0;
            tmpl          <= '0;
            nonce         <= 32'd0;
            hit_nonce_reg <= 32'd0;
`ifdef SHA_NONCE_SWEEP_EN
            remaining     <= 32'd0;
`endif
        end else begin
            state <= state_nxt;
            rnd   <= rnd_nxt;
            // K is registered so it lines up with the round it belongs to
            k_reg <= (state_nxt == ROUND) ? K_TAB[rnd_nxt] : 32'd0;
            if (accept) begin
                tmpl          <= bus.job_template;
                nonce         <= bus.nonce_start;
                hit_nonce_reg <= 32'd0;
`ifdef SHA_NONCE_SWEEP_EN
                remaining     <= (bus.nonce_count == 32'd0) ? 32'd1 : bus.nonce_count;
`endif
            end else if (state == CHECK && !bus.abort) begin
                if (bus.found) begin
                    hit_nonce_reg <= nonce;
                end
`ifdef SHA_NONCE_SWEEP_EN
                else if (!last) begin
                    nonce     <= nonce + 32'd1;
                    remaining <= remaining - 32'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Randomized bench for sha256_round_ctrl with a stub core raising found on a chosen nonce.
// Expected behaviour comes from a per-cycle schedule model and a K table derived from prime cube roots.
module tb_sha256_round_ctrl;

    logic clk_fast = 1'b0;
    logic rst      = 1'b1;
    always #5 clk_fast = ~clk_fast;

    sha256_round_ctrl_if bus ();

    sha256_round_ctrl #(.NONCE_LSB(96)) dut (
        .clk_fast(clk_fast),
        .rst     (rst),
        .bus     (bus)
    );

    bit          stub_en  = 1'b0;
    logic [31:0] stub_tgt = 32'd0;
    assign bus.found = stub_en && (bus.message[127:96] == stub_tgt);

    int checks   = 0;
    int failures = 0;
    logic [31:0] k_ref [64];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // K[t] = first 32 fractional bits of the cube root of the t-th prime
    task automatic build_k_ref();
        int  n = 2;
        int  cnt = 0;
        bit  prime;
        real r, f;
        while (cnt < 64) begin
            prime = 1'b1;
            for (int d = 2; d * d <= n; d++) if (n % d == 0) prime = 1'b0;
            if (prime) begin
                r = $pow(real'(n), 1.0 / 3.0);
                r = r - (r * r * r - real'(n)) / (3.0 * r * r);
                f = r - $floor(r);
                k_ref[cnt] = 32'(longint'($floor(f * 4294967296.0)));
                cnt++;
            end
            n++;
        end
    endtask

    task automatic chk_idle(input logic [31:0] hn_exp);
        chk("idle_start", bus.start, 1'b0);
        chk("idle_irst", bus.idle_rst, 1'b0);
        chk("idle_rotw", bus.rotate_W, 1'b0);
        chk("idle_ren", bus.round_enable, 1'b0);
        chk("idle_ela", bus.enable_last_addition, 1'b0);
        chk("idle_round", bus.round, 7'd0);
        chk("idle_k", bus.K, 32'd0);
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_done", bus.done, 1'b0);
        chk("idle_ready", bus.job_ready, 1'b1);
        chk("idle_hit_nonce", bus.hit_nonce, hn_exp);
    endtask

    // kill_kind: 0 none, 1 abort at cycle offset kill_d, 2 rst at kill_d
    task automatic run_job(input logic [31:0] st, input logic [31:0] cnt, input bit hen,
                           input logic [31:0] tgt, input int kill_d_in, input int kill_kind);
        logic [511:0] tmpl, msg_exp;
        logic [31:0]  nz;
        logic [6:0]   e_round;
        logic [31:0]  e_k;
        bit           e_start, e_irst, e_rot, e_ren, e_ela, e_done;
        int           eff, hit_idx, end_d, last_d, kill_d, n, p, t;

        @(negedge clk_fast);
        for (int i = 0; i < 16; i++) tmpl[i*32 +: 32] = $urandom;
        stub_en          = hen;
        stub_tgt         = tgt;
        bus.job_template = tmpl;
        bus.nonce_start  = st;
        bus.nonce_count  = cnt;
        bus.job_valid    = 1'b1;
        #1 chk("ready_before_accept", bus.job_ready, 1'b1);

`ifdef SHA_NONCE_SWEEP_EN
        eff = (cnt == 32'd0) ? 1 : int'(cnt);
`else
        eff = 1;
`endif
        hit_idx = -1;
        for (int i = 0; i < eff; i++) begin
            nz = st + 32'(i);
            if (hen && nz == tgt && hit_idx < 0) hit_idx = i;
        end
        end_d  = 68 * ((hit_idx >= 0) ? hit_idx + 1 : eff);
        kill_d = kill_d_in;
        if (kill_kind == 1 && kill_d > end_d)  kill_d = end_d;
        if (kill_kind == 2 && kill_d >= end_d) kill_d = end_d - 1;
        last_d = (kill_kind != 0) ? kill_d : end_d;

        for (int d = 1; d <= last_d + 1; d++) begin
            @(negedge clk_fast);
            if (kill_kind == 1 && d == kill_d) bus.abort = 1'b1;
            if (kill_kind == 2 && d == kill_d) rst = 1'b1;
            bus.job_valid = (d < last_d) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (bus.job_valid) begin
                bus.nonce_start         = $urandom;
                bus.nonce_count         = $urandom;
                bus.job_template[31:0]  = $urandom;
            end
            #1;
            if (d > last_d) begin
                chk_idle((kill_kind == 0 && hit_idx >= 0) ? tgt : 32'd0);
                if (kill_kind == 2) chk("rst_message", bus.message, 512'd0);
                bus.abort = 1'b0;
                rst       = 1'b0;
            end else begin
                n = (d - 1) / 68;
                p = (d - 1) % 68;
                {e_start, e_irst, e_rot, e_ren, e_ela} = '0;
                e_round = 7'd0;
                e_k     = 32'd0;
                if (p == 0) begin
                    e_start = 1'b1; e_irst = 1'b1;
                end else if (p == 1) begin
                    e_rot = 1'b1;
                end else if (p <= 65) begin
                    t       = p - 2;
                    e_ren   = 1'b1;
                    e_rot   = (t < 63);
                    e_round = 7'(t);
                    e_k     = k_ref[t];
                    if (t == 0)  chk("k_round0", bus.K, 32'h428a2f98);
                    if (t == 1)  chk("k_round1", bus.K, 32'h71374491);
                    if (t == 63) chk("k_round63", bus.K, 32'hc67178f2);
                end else if (p == 66) begin
                    e_ela = 1'b1; e_round = 7'd64;
                end else begin
                    e_round = 7'd64;
                end
                msg_exp = tmpl;
                msg_exp[96 +: 32] = st + 32'(n);
                e_done = (d == end_d) && !(kill_kind == 1 && d == kill_d);
                chk("start", bus.start, e_start);
                chk("idle_rst", bus.idle_rst, e_irst);
                chk("rotate_W", bus.rotate_W, e_rot);
                chk("round_enable", bus.round_enable, e_ren);
                chk("last_add", bus.enable_last_addition, e_ela);
                chk("round", bus.round, e_round);
                chk("K", bus.K, e_k);
                chk("message", bus.message, msg_exp);
                chk("busy", bus.busy, 1'b1);
                chk("job_ready_busy", bus.job_ready, 1'b0);
                chk("hit_nonce_busy", bus.hit_nonce, 32'd0);
                chk("done", bus.done, e_done);
                if (e_done) chk("hit", bus.hit, hit_idx >= 0);
            end
        end
    endtask

    initial begin
        logic [31:0] st, tgt;
        bus.job_valid    = 1'b0;
        bus.job_template = '0;
        bus.nonce_start  = 32'd0;
        bus.nonce_count  = 32'd0;
        bus.abort        = 1'b0;
        build_k_ref();

        repeat (3) @(negedge clk_fast);
        chk_idle(32'd0);
        chk("reset_message", bus.message, 512'd0);
        chk("reset_hit", bus.hit, 1'b0);
        rst = 1'b0;

        run_job(32'd2, 32'd10, 1'b1, 32'd5, 0, 0);
        run_job(32'hFFFFFFFF, 32'd2, 1'b0, 32'd0, 0, 0);
        run_job($urandom, 32'd3, 1'b0, 32'd0, 33, 1);
        run_job($urandom, 32'd3, 1'b0, 32'd0, 13, 2);
        run_job(32'd7, 32'd0, 1'b0, 32'd0, 0, 0);
        st = $urandom;
        run_job(st, 32'd1, 1'b1, st, 0, 0);
        run_job(st, 32'd2, 1'b1, st, 68, 1);

        for (int j = 0; j < 8; j++) begin
            st  = $urandom;
            tgt = st + 32'($urandom_range(0, 4));
            run_job(st, 32'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), tgt,
                    int'($urandom_range(1, 300)), int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 3)) @(negedge clk_fast);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
